// File: rtl/final_logic_pkg.sv
// rtl/final_logic_pkg.sv - shared types and constants for the final_logic receive path
//
// Contents:
//   state_t        control FSM encoding (RESET/INIT/IDLE/ACTIVE)
//   DATA_WIDTH_DEF default word width
//   ADDR_WIDTH_DEF default output FIFO address width
//   DEPTH_DEF      default output FIFO depth
//   DEST_BIT       destination-select bit for the default word width
//   THR_WIDTH      width of the almost-full thresholds
//   depth_of()     FIFO depth for a given address width

package final_logic_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
  localparam int DEST_BIT       = DATA_WIDTH_DEF - 1;
  localparam int THR_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/final_logic_out.sv
// rtl/final_logic_out.sv - output FIFO with latched-threshold almost_full and sticky error
//
// Module out_fifo ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   clear_err    in   clears the sticky error flag
//   thr_valid    in   threshold has been latched; gates almost_full
//   threshold    in   almost-full threshold
//   push         in   write strobe
//   push_data    in   write data
//   pop          in   read strobe
//   data_out     out  registered read data, holds when no successful pop
//   empty, full  out  occupancy status
//   almost_full  out  count >= threshold
//   error        out  sticky: pop while empty, or push dropped because full

module out_fifo
  import final_logic_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH_DEF,
  parameter int address_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_err,
  input  logic                  thr_valid,
  input  logic [THR_WIDTH-1:0]  threshold,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  error
);

  localparam int depth = depth_of(address_width);
  localparam logic [address_width:0] full_count = (address_width + 1)'(depth);

  logic [data_width-1:0]    mem [depth];
  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic [address_width:0]   count;
  logic                     do_push;
  logic                     do_pop;

  assign empty = (count == '0);
  assign full  = (count == full_count);

  // Until a threshold has been latched the flag stays low, so the reset
  // value of almost_full is 0 even though the cleared threshold is 0.
  assign almost_full = thr_valid && (int'(count) >= int'(threshold));

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when a read frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      error    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (clear_err) begin
        error <= 1'b0;
      end else if ((pop && empty) || (push && !do_push)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/final_logic.sv
// rtl/final_logic.sv - drains VC0/VC1 FIFOs by strict priority into destination FIFOs D0/D1
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   init                        enter INIT and latch thresholds
//   Umbral_D0, Umbral_D1        almost-full thresholds, latched in INIT
//   data_in_VC0/VC1             VC FIFO read data, valid the cycle after a pop
//   empty_fifo_VC0/VC1          VC FIFO empty flags
//   pop_D0, pop_D1              downstream reads of D0/D1
//   pop_VC0_fifo/VC1_fifo       read strobes to the VC FIFOs
//   data_out_D0/D1              registered read data of D0/D1
//   empty/full/almost_full/error_D0/D1  output FIFO status
//   idle_out                    high only in IDLE

module final_logic
  import final_logic_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH_DEF,
  parameter int address_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [THR_WIDTH-1:0]  Umbral_D0,
  input  logic [THR_WIDTH-1:0]  Umbral_D1,
  input  logic [data_width-1:0] data_in_VC0,
  input  logic [data_width-1:0] data_in_VC1,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic                  pop_D0,
  input  logic                  pop_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
  output logic                  empty_D0,
  output logic                  empty_D1,
  output logic                  full_D0,
  output logic                  full_D1,
  output logic                  almost_full_D0,
  output logic                  almost_full_D1,
  output logic                  error_D0,
  output logic                  error_D1,
  output logic                  idle_out
);

  localparam int dest_bit = data_width - 1;

  state_t                state_q;
  state_t                state_d;
  logic [THR_WIDTH-1:0]  umbral_d0_q;
  logic [THR_WIDTH-1:0]  umbral_d1_q;
  logic                  thr_loaded_q;
  logic                  inflight_q;
  logic                  vc_sel_q;
  logic                  in_init;
  logic                  pause;
  logic                  drained;
  logic [data_width-1:0] route_word;
  logic                  push_d0;
  logic                  push_d1;

  assign in_init = (state_q == ST_INIT);
  assign pause   = almost_full_D0 || almost_full_D1;
  assign drained = empty_fifo_VC0 && empty_fifo_VC1 && empty_D0 && empty_D1 && !inflight_q;

  always_comb begin
    state_d      = state_q;
    pop_VC0_fifo = 1'b0;
    pop_VC1_fifo = 1'b0;
    idle_out     = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        idle_out     = 1'b1;
        pop_VC0_fifo = !pause && !empty_fifo_VC0;
        pop_VC1_fifo = !pause && empty_fifo_VC0 && !empty_fifo_VC1;
        if (init) begin
          state_d = ST_INIT;
        end else if (!empty_fifo_VC0 || !empty_fifo_VC1) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        pop_VC0_fifo = !pause && !empty_fifo_VC0;
        pop_VC1_fifo = !pause && empty_fifo_VC0 && !empty_fifo_VC1;
        if (init) begin
          state_d = ST_INIT;
        end else if (drained) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // The in-flight register is not gated by the FSM: a word popped just
  // before entering INIT still lands in its destination FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      umbral_d0_q  <= '0;
      umbral_d1_q  <= '0;
      thr_loaded_q <= 1'b0;
      inflight_q   <= 1'b0;
      vc_sel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= pop_VC0_fifo || pop_VC1_fifo;
      vc_sel_q   <= pop_VC1_fifo;
      if (in_init) begin
        umbral_d0_q  <= Umbral_D0;
        umbral_d1_q  <= Umbral_D1;
        thr_loaded_q <= 1'b1;
      end
    end
  end

  assign route_word = vc_sel_q ? data_in_VC1 : data_in_VC0;
  assign push_d0    = inflight_q && !route_word[dest_bit];
  assign push_d1    = inflight_q && route_word[dest_bit];

  out_fifo #(
    .data_width   (data_width),
    .address_width(address_width)
  ) u_fifo_d0 (
    .clk        (clk),
    .reset      (reset),
    .clear_err  (in_init),
    .thr_valid  (thr_loaded_q),
    .threshold  (umbral_d0_q),
    .push       (push_d0),
    .push_data  (route_word),
    .pop        (pop_D0),
    .data_out   (data_out_D0),
    .empty      (empty_D0),
    .full       (full_D0),
    .almost_full(almost_full_D0),
    .error      (error_D0)
  );

  out_fifo #(
    .data_width   (data_width),
    .address_width(address_width)
  ) u_fifo_d1 (
    .clk        (clk),
    .reset      (reset),
    .clear_err  (in_init),
    .thr_valid  (thr_loaded_q),
    .threshold  (umbral_d1_q),
    .push       (push_d1),
    .push_data  (route_word),
    .pop        (pop_D1),
    .data_out   (data_out_D1),
    .empty      (empty_D1),
    .full       (full_D1),
    .almost_full(almost_full_D1),
    .error      (error_D1)
  );

endmodule

// File: tb/tb_final_logic.sv
// tb/tb_final_logic.sv - randomized self-checking bench for final_logic with a queue-based reference model

module tb_final_logic;

  localparam int DW    = 6;
  localparam int DEPTH = 4;

  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [3:0]    Umbral_D0;
  logic [3:0]    Umbral_D1;
  logic [DW-1:0] data_in_VC0;
  logic [DW-1:0] data_in_VC1;
  logic          empty_fifo_VC0;
  logic          empty_fifo_VC1;
  logic          pop_D0;
  logic          pop_D1;
  logic          pop_VC0_fifo;
  logic          pop_VC1_fifo;
  logic [DW-1:0] data_out_D0;
  logic [DW-1:0] data_out_D1;
  logic          empty_D0, empty_D1, full_D0, full_D1;
  logic          almost_full_D0, almost_full_D1;
  logic          error_D0, error_D1;
  logic          idle_out;

  always #5 clk = ~clk;

  final_logic dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .Umbral_D0     (Umbral_D0),
    .Umbral_D1     (Umbral_D1),
    .data_in_VC0   (data_in_VC0),
    .data_in_VC1   (data_in_VC1),
    .empty_fifo_VC0(empty_fifo_VC0),
    .empty_fifo_VC1(empty_fifo_VC1),
    .pop_D0        (pop_D0),
    .pop_D1        (pop_D1),
    .pop_VC0_fifo  (pop_VC0_fifo),
    .pop_VC1_fifo  (pop_VC1_fifo),
    .data_out_D0   (data_out_D0),
    .data_out_D1   (data_out_D1),
    .empty_D0      (empty_D0),
    .empty_D1      (empty_D1),
    .full_D0       (full_D0),
    .full_D1       (full_D1),
    .almost_full_D0(almost_full_D0),
    .almost_full_D1(almost_full_D1),
    .error_D0      (error_D0),
    .error_D1      (error_D1),
    .idle_out      (idle_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Source VC FIFOs (bench side) and reference model state
  logic [DW-1:0] vc0[$];
  logic [DW-1:0] vc1[$];
  logic [DW-1:0] dq[2][$];
  logic [DW-1:0] mdo[2];
  bit            merr[2];
  int            thr[2];
  bit            loaded;
  int            ph;
  bit            mfly;
  logic [DW-1:0] mfly_word;

  function automatic bit exp_af(input int i);
    return loaded && (dq[i].size() >= thr[i]);
  endfunction

  function automatic bit exp_pop(input int ch);
    bit go;
    go = (ph == M_IDLE || ph == M_ACTIVE) && !(exp_af(0) || exp_af(1));
    if (ch == 0) return go && (vc0.size() > 0);
    return go && (vc0.size() == 0) && (vc1.size() > 0);
  endfunction

  task automatic model_reset();
    ph      = M_RESET;
    dq[0].delete();
    dq[1].delete();
    mdo[0]  = '0;
    mdo[1]  = '0;
    merr[0] = 1'b0;
    merr[1] = 1'b0;
    thr[0]  = 0;
    thr[1]  = 0;
    loaded  = 1'b0;
    mfly    = 1'b0;
    mfly_word = '0;
  endtask

  task automatic compare_outputs();
    check_eq("pop_vc0",  32'(pop_VC0_fifo),   32'(exp_pop(0)));
    check_eq("pop_vc1",  32'(pop_VC1_fifo),   32'(exp_pop(1)));
    check_eq("data_d0",  32'(data_out_D0),    32'(mdo[0]));
    check_eq("data_d1",  32'(data_out_D1),    32'(mdo[1]));
    check_eq("empty_d0", 32'(empty_D0),       32'(dq[0].size() == 0));
    check_eq("empty_d1", 32'(empty_D1),       32'(dq[1].size() == 0));
    check_eq("full_d0",  32'(full_D0),        32'(dq[0].size() == DEPTH));
    check_eq("full_d1",  32'(full_D1),        32'(dq[1].size() == DEPTH));
    check_eq("af_d0",    32'(almost_full_D0), 32'(exp_af(0)));
    check_eq("af_d1",    32'(almost_full_D1), 32'(exp_af(1)));
    check_eq("err_d0",   32'(error_D0),       32'(merr[0]));
    check_eq("err_d1",   32'(error_D1),       32'(merr[1]));
    check_eq("idle",     32'(idle_out),       32'(ph == M_IDLE));
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit            e0, e1, vc_any, all_drained, set, rd, wr;
    logic [DW-1:0] w;
    if (!reset) return;
    e0 = exp_pop(0);
    e1 = exp_pop(1);
    vc_any = (vc0.size() > 0) || (vc1.size() > 0);
    all_drained = !vc_any && dq[0].size() == 0 && dq[1].size() == 0 && !mfly;
    for (int i = 0; i < 2; i++) begin
      set = 1'b0;
      rd  = (i == 0) ? pop_D0 : pop_D1;
      wr  = mfly && (int'(mfly_word[DW-1]) == i);
      if (rd) begin
        if (dq[i].size() > 0) mdo[i] = dq[i].pop_front();
        else set = 1'b1;
      end
      if (wr) begin
        if (dq[i].size() < DEPTH) dq[i].push_back(mfly_word);
        else set = 1'b1;
      end
      if (ph == M_INIT) merr[i] = 1'b0;
      else if (set) merr[i] = 1'b1;
    end
    if (ph == M_INIT) begin
      thr[0] = int'(Umbral_D0);
      thr[1] = int'(Umbral_D1);
      loaded = 1'b1;
    end
    w = '0;
    if (e0) w = vc0[0];
    else if (e1) w = vc1[0];
    case (ph)
      M_RESET: ph = M_INIT;
      M_INIT:  if (!init) ph = M_IDLE;
      M_IDLE:  if (init) ph = M_INIT; else if (vc_any) ph = M_ACTIVE;
      default: if (init) ph = M_INIT; else if (all_drained) ph = M_IDLE;
    endcase
    mfly      = e0 || e1;
    mfly_word = w;
  endtask

  task automatic update_empties();
    empty_fifo_VC0 = (vc0.size() == 0);
    empty_fifo_VC1 = (vc1.size() == 0);
  endtask

  task automatic add_vc(input int ch, input logic [DW-1:0] val);
    if (ch == 0) vc0.push_back(val);
    else vc1.push_back(val);
    update_empties();
  endtask

  task automatic cycle();
    bit p0, p1;
    @(negedge clk);
    compare_outputs();
    p0 = pop_VC0_fifo;
    p1 = pop_VC1_fifo;
    model_step();
    @(posedge clk);
    #1;
    if (p0 && vc0.size() > 0) data_in_VC0 = vc0.pop_front();
    if (p1 && vc1.size() > 0) data_in_VC1 = vc1.pop_front();
    update_empties();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_init(input logic [3:0] u0, input logic [3:0] u1);
    Umbral_D0 = u0;
    Umbral_D1 = u1;
    init = 1'b1;
    run(2);
    init = 1'b0;
    run(2);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      pop_D0 = (dq[0].size() > 0);
      pop_D1 = (dq[1].size() > 0);
      cycle();
    end
    pop_D0 = 1'b0;
    pop_D1 = 1'b0;
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    vc0.delete();
    vc1.delete();
    update_empties();
    run(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; Umbral_D0 = '0; Umbral_D1 = '0;
    data_in_VC0 = '0; data_in_VC1 = '0; pop_D0 = 1'b0; pop_D1 = 1'b0;
    update_empties();
    model_reset();
    #3;
    compare_outputs();
    run(2);

    // Reset release, threshold latch, IDLE
    reset = 1'b1;
    init = 1'b1; Umbral_D0 = 4'd3; Umbral_D1 = 4'd3;
    run(3);
    init = 1'b0;
    run(2);
    check_eq("init_idle", 32'(idle_out), 32'd1);

    // Strict priority and routing by destination bit
    add_vc(0, 6'h05); add_vc(0, 6'h25); add_vc(1, 6'h21);
    run(7);
    pop_D0 = 1'b1; cycle(); pop_D0 = 1'b0;
    check_eq("prio_d0_first", 32'(data_out_D0), 32'h05);
    pop_D1 = 1'b1; cycle();
    check_eq("prio_d1_first", 32'(data_out_D1), 32'h25);
    cycle(); pop_D1 = 1'b0;
    check_eq("prio_d1_second", 32'(data_out_D1), 32'h21);
    run(3);

    // Pop-to-entry latency of two edges, registered read one cycle later
    add_vc(1, 6'h2A);
    cycle();
    check_eq("lat_empty_after_1", 32'(empty_D1), 32'd1);
    cycle();
    check_eq("lat_empty_after_2", 32'(empty_D1), 32'd0);
    pop_D1 = 1'b1; cycle(); pop_D1 = 1'b0;
    check_eq("lat_data_d1", 32'(data_out_D1), 32'h2A);
    run(3);

    // Back-pressure with threshold 2 on D0
    do_init(4'd2, 4'd3);
    for (int k = 1; k <= 4; k++) add_vc(0, 6'(k));
    run(10);
    check_eq("bp_no_full", 32'(full_D0), 32'd0);
    check_eq("bp_no_error", 32'(error_D0), 32'd0);
    check_eq("bp_vc0_held", 32'(empty_fifo_VC0), 32'd0);
    drain(20);
    run(3);

    // Underflow sets a sticky error that INIT clears
    pop_D0 = 1'b1; cycle(); pop_D0 = 1'b0;
    check_eq("uf_set", 32'(error_D0), 32'd1);
    run(3);
    check_eq("uf_sticky", 32'(error_D0), 32'd1);
    do_init(4'd3, 4'd3);
    check_eq("uf_cleared", 32'(error_D0), 32'd0);

    // Threshold 0 blocks every pop
    do_init(4'd0, 4'd3);
    add_vc(0, 6'h11);
    run(5);
    check_eq("block_d0_empty", 32'(empty_D0), 32'd1);
    do_init(4'd3, 4'd3);
    run(4);
    drain(10);
    run(3);
    check_eq("drain_idle", 32'(idle_out), 32'd1);

    // Randomized traffic with occasional re-init
    for (int c = 0; c < 400; c++) begin
      if (vc0.size() < 6 && $urandom_range(0, 2) == 0) add_vc(0, 6'($urandom));
      if (vc1.size() < 6 && $urandom_range(0, 2) == 0) add_vc(1, 6'($urandom));
      pop_D0 = ($urandom_range(0, 2) == 0);
      pop_D1 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) begin
        Umbral_D0 = 4'($urandom_range(1, 3));
        Umbral_D1 = 4'($urandom_range(1, 3));
        init = 1'b1;
      end else begin
        init = 1'b0;
      end
      cycle();
    end
    init = 1'b0; pop_D0 = 1'b0; pop_D1 = 1'b0;
    run(2);
    repeat (3) begin
      drain(20);
      run(2);
    end
    run(3);
    check_eq("rand_drain_idle", 32'(idle_out), 32'd1);

    // Reset during a transfer loses the in-flight word
    add_vc(0, 6'h07); add_vc(1, 6'h33);
    cycle();
    mid_reset();
    do_init(4'd3, 4'd3);
    run(4);
    check_eq("rst_d0_empty", 32'(empty_D0), 32'd1);
    check_eq("rst_d1_empty", 32'(empty_D1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/final_logic.md
Name: final_logic

Overview:
- Receive-side counterpart of the initial transmit logic; drains the VC0/VC1 virtual-channel FIFOs toward the physical destinations.
- Strict-priority arbiter pops VC0 before VC1; each popped word is routed by its destination bit into one of two output FIFOs (D0, D1).
- Back-pressure: pops stop while either output FIFO is almost full.
- Contains a small control FSM (RESET/INIT/IDLE/ACTIVE) that latches thresholds and reports idle status.

Parameters:
- data_width, 6, word width; bit [data_width-1] is the destination select (0 -> D0, 1 -> D1).
- address_width, 2, output FIFO address bits; depth = 2**address_width = 4.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- init  in  1  1 enters INIT and latches thresholds.
- Umbral_D0  in  4  D0 almost-full threshold, latched in INIT.
- Umbral_D1  in  4  D1 almost-full threshold, latched in INIT.
- data_in_VC0  in  data_width  VC0 FIFO read data, valid the cycle after its pop.
- data_in_VC1  in  data_width  VC1 FIFO read data, valid the cycle after its pop.
- empty_fifo_VC0  in  1  VC0 FIFO empty.
- empty_fifo_VC1  in  1  VC1 FIFO empty.
- pop_D0  in  1  downstream read of D0.
- pop_D1  in  1  downstream read of D1.
- pop_VC0_fifo  out  1  read strobe to VC0.
- pop_VC1_fifo  out  1  read strobe to VC1.
- data_out_D0  out  data_width  D0 registered read data.
- data_out_D1  out  data_width  D1 registered read data.
- empty_D0, empty_D1, full_D0, full_D1  out  1 each  output FIFO status.
- almost_full_D0, almost_full_D1  out  1 each  count >= Umbral_Dx (latched value).
- error_D0, error_D1  out  1 each  sticky overflow/underflow flag.
- idle_out  out  1  1 only in IDLE.

Behaviour:
- Reset (reset=0): FSM=RESET; FIFO pointers and counts cleared; all data_out=0, empty=1, full/almost_full/error=0, pops=0, idle_out=0, latched thresholds=0, in-flight register cleared.
- FSM transitions:
  - RESET -> INIT on the first clk with reset=1.
  - INIT: latch Umbral_D0/D1 every cycle; no pops. Leave to IDLE when init=0.
  - IDLE -> ACTIVE when any VC is non-empty.
  - ACTIVE -> IDLE when both VCs are empty, both D FIFOs are empty, and no pop is in flight.
  - init=1 from IDLE or ACTIVE -> INIT. The in-flight word still completes its push.
- Arbitration (combinational, only in IDLE/ACTIVE):
  - pause = almost_full_D0 | almost_full_D1.
  - pop_VC0_fifo = !pause & !empty_fifo_VC0.
  - pop_VC1_fifo = !pause & empty_fifo_VC0 & !empty_fifo_VC1.
  - At most one pop per cycle; back-to-back pops allowed.
- Routing and latency:
  - A pop in cycle N sets a registered valid and a vc_sel bit for cycle N+1.
  - In N+1, the word is selected from data_in_VC0 or data_in_VC1 per vc_sel, and its top bit picks D0 or D1.
  - The selected D FIFO is written on the edge ending N+1.
  - Pop-to-D-FIFO-entry latency is 2 edges. The word is visible on data_out_Dx one cycle after a pop_Dx.
- Output FIFOs:
  - Registered read: data_out updates on pop when non-empty, otherwise holds.
  - Simultaneous push and pop: count unchanged, both operations performed.
  - Push when full: word dropped, error set. Pop when empty: data_out holds, error set.
  - error clears only on reset or INIT.
  - Pointers wrap modulo depth.
- Slack: the pause asserts one cycle late relative to the in-flight word, so Umbral must be <= depth-1. With Umbral=0, almost_full is permanently 1, which disables all pops (intended blocking configuration).
- reset asserted mid-transfer: the in-flight word is lost; no partial state survives.

Decomposition:
- Shared package holds:
  - FSM state encodings: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
  - DEST_BIT = data_width-1.
  - Default depth constant.
- One sub-module, out_fifo: parameterised FIFO with threshold, almost_full and sticky error, instantiated twice (D0, D1).
- Arbiter, routing register and FSM stay in final_logic.

Test Plan:
- Reset/init: assert reset=0 mid-cycle -> all outputs at reset values immediately; release, init=1 with Umbral_D0=3, Umbral_D1=3, then init=0 -> FSM reaches IDLE, idle_out=1.
- Priority: both VCs non-empty, VC0 holds 0x05 and 0x25, VC1 holds 0x21 -> pops VC0, VC0, then VC1; D0 receives 0x05; D1 receives 0x25 then 0x21, in order.
- Latency: single pop of 0x2A from VC1 at cycle N -> full_D1/empty_D1 update after edge N+2; pop_D1 then gives data_out_D1=0x2A one cycle later.
- Back-pressure: Umbral_D0=2, no pop_D0, VC0 streams 0x01..0x04 -> pops stop once count_D0=2; count_D0 never exceeds 3; no error_D0.
- Underflow/overflow: pop_D0 while empty -> error_D0=1 and sticky; init pulse -> error_D0=0.
- Drain to idle: after all traffic, read out D0/D1 -> idle_out returns to 1 only when both VC empties and both D empties are 1.
